// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC and fetches one word at a time over req/gnt/rvalid. Optional misaligned-branch trap: FETCH_MISALIGN_TRAP_EN.
// Latency: 3 cycles minimum per instruction (REQ with gnt, WAIT with rvalid, HOLD with ready).
// Backpressure: Instr/pc_o are held until instr_ready; memory gnt and rvalid may each be delayed indefinitely.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic [31:0] pc_o,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PCsrc,
   input  logic [31:0] ImmOp,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_ERR  = 2'd3
   } state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
   // A misaligned reset PC never raises a request; it is trapped on the first cycle.
   localparam logic REQ_RST = (RESET_PC[1:0] == 2'b00);
`else
   localparam logic REQ_RST = 1'b1;
`endif

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic [31:0] next_pc;

   assign next_pc = pc_q + (PCsrc ? ImmOp : PC_STEP);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      req_d      = req_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_d      = err_q;
`endif
      case (state_q)
         S_REQ: begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (fetch_pc_q[1:0] != 2'b00) begin
               state_d = S_ERR;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else
`endif
            if (imem_gnt) begin
               state_d = S_WAIT;
               req_d   = 1'b0;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               pc_d    = fetch_pc_q;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ready) begin
               valid_d    = 1'b0;
               fetch_pc_d = next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (PCsrc && (next_pc[1:0] != 2'b00)) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
               end
`else
               state_d = S_REQ;
               req_d   = 1'b1;
`endif
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_ERR: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
`endif
         default: begin
            state_d = S_REQ;
            req_d   = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         instr_q    <= 32'h0;
         pc_q       <= 32'h0;
         valid_q    <= 1'b0;
         req_q      <= REQ_RST;
`ifdef FETCH_MISALIGN_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         req_q      <= req_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         err_q      <= err_d;
`endif
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = fetch_pc_q;
   assign Instr       = instr_q;
   assign pc_o        = pc_q;
   assign instr_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign fetch_err   = err_q;
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory/decode driver with a PC reference model, scoreboard monitor on the output handshake.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic [31:0] pc_o;
   logic        instr_valid;
   logic        instr_ready;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic        fetch_err;

   instr_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .Instr       (Instr),
      .pc_o        (pc_o),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .PCsrc       (PCsrc),
      .ImmOp       (ImmOp),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        sb_q[$];
   int          vectors;
   int          miscompares;
   logic [31:0] exp_pc;   // reference model: address the next fetch must use
   logic        exp_err;
   int          hs_cyc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0008) return 32'h00A0_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle advance; decode side waves random PCsrc/ImmOp that must be ignored unless consumed.
   task automatic step();
      @(negedge clk);
      #1;
      PCsrc = 1'($urandom_range(0, 1));
      ImmOp = $urandom;
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            chk("fetch_err", 32'(fetch_err), 32'(exp_err));
            if (instr_valid) begin
               chk("req_while_valid", 32'(imem_req), 32'd0);
               if (sb_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL sb_empty: instr_valid=1 pc_o=%h, expected no output", pc_o);
               end else begin
                  chk("instr", Instr, sb_q[0].ins);
                  chk("pc_o", pc_o, sb_q[0].pc);
                  if (instr_ready) void'(sb_q.pop_front());
               end
            end
         end
      end
   endtask

   // Serve one fetch with gd grant-wait cycles, rd extra rvalid cycles, stall ready-low cycles.
   task automatic do_instr(input int gd, input int rd, input int stall, input bit br, input logic [31:0] imm);
      int n;
      logic [31:0] a;
      n = 0;
      while (!imem_req && n < 50) begin
         step();
         n++;
      end
      chk("req_seen", 32'(imem_req), 32'd1);
      a = imem_addr;
      chk("fetch_addr", a, exp_pc);
      for (int i = 0; i < gd; i++) begin
         step();
         chk("req_hold", 32'(imem_req), 32'd1);
         chk("addr_stable", imem_addr, a);
      end
      imem_gnt = 1'b1;
      sb_q.push_back('{pc: a, ins: mem_word(a)});
      step();
      imem_gnt = 1'b0;
      chk("req_drop", 32'(imem_req), 32'd0);
      for (int i = 0; i < rd; i++) begin
         step();
         chk("req_wait", 32'(imem_req), 32'd0);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      chk("valid_up", 32'(instr_valid), 32'd1);
      for (int i = 0; i < stall; i++) step();
      instr_ready = 1'b1;
      PCsrc       = br;
      ImmOp       = imm;
      hs_cyc      = cyc;
      exp_pc      = a + (br ? imm : 32'd4);
      step();
      instr_ready = 1'b0;
      chk("valid_drop", 32'(instr_valid), 32'(0));
   endtask

   initial begin
      int prev;
      logic [31:0] a;
      int n;
      vectors     = 0;
      miscompares = 0;
      exp_pc      = RESET_PC;
      exp_err     = 1'b0;
      rst_n       = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;
      PCsrc       = 1'b0;
      ImmOp       = 32'h0;
      fork
         monitor();
      join_none
      #1 rst_n = 1'b0;
      #2;
      chk("rst_instr", Instr, 32'h0);
      chk("rst_pc_o", pc_o, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      #9 rst_n = 1'b1;
      step();

      // Sequential fetch at full rate: 0,4,8,C then 0x10 branches back by 8.
      do_instr(0, 0, 0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         prev = hs_cyc;
         do_instr(0, 0, 0, 1'b0, 32'h0);
         chk("throughput", 32'(hs_cyc - prev), 32'd3);
      end
      do_instr(0, 0, 0, 1'b1, 32'hFFFF_FFF8);
      // Back at 0x08: 5-cycle decode stall, then memory backpressure.
      do_instr(0, 0, 5, 1'b0, 32'h0);
      do_instr(4, 3, 0, 1'b0, 32'h0);
      // Wrap: branch to 0xFFFFFFFC, then the sequential step lands on 0.
      do_instr(0, 1, 1, 1'b1, 32'hFFFF_FFFC - exp_pc);
      do_instr(1, 0, 0, 1'b0, 32'h0);
      do_instr(0, 0, 0, 1'b0, 32'h0);

      for (int k = 0; k < 60; k++) begin
         do_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0),
                  32'($urandom_range(0, 511)) * 32'd4 - 32'd1024);
      end

      // Asynchronous reset between edges while a response is outstanding.
      n = 0;
      while (!imem_req && n < 50) begin
         step();
         n++;
      end
      a = imem_addr;
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_instr", Instr, 32'h0);
      chk("arst_pc_o", pc_o, 32'h0);
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_req", 32'(imem_req), 32'd1);
      chk("arst_addr", imem_addr, RESET_PC);
      #1 rst_n = 1'b1;
      sb_q.delete();
      exp_pc = RESET_PC;
      step();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      step();
      imem_rvalid = 1'b0;
      chk("late_rvalid_valid", 32'(instr_valid), 32'd0);
      chk("late_rvalid_req", 32'(imem_req), 32'd1);
      do_instr(0, 0, 0, 1'b0, 32'h0);

      // Misaligned branch target from 0x20 with offset 6.
      do_instr(0, 0, 0, 1'b1, 32'h20 - exp_pc);
      do_instr(0, 0, 0, 1'b1, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_err = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("err_req", 32'(imem_req), 32'd0);
         chk("err_valid", 32'(instr_valid), 32'd0);
      end
`else
      do_instr(0, 0, 0, 1'b0, 32'h0);
      do_instr(0, 0, 0, 1'b0, 32'h0);
`endif
      step();
      step();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
